// File: rtl/rv_lsu_pkg.sv
// Shared constants, FSM state encoding and funct3 legality helper for the
// RV32I load/store bus bridge.
package rv_lsu_pkg;

  localparam int LSU_BE_W = 4;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'd0,
    LSU_WAIT_GNT    = 2'd1,
    LSU_WAIT_RVALID = 2'd2,
    LSU_DONE        = 2'd3
  } lsu_state_e;

  // Unsigned variants only make sense for loads.
  function automatic logic lsu_funct3_legal(input logic [2:0] funct3, input logic we);
    logic ok;
    case (funct3)
      LSU_B, LSU_H, LSU_W: ok = 1'b1;
      LSU_BU, LSU_HU:      ok = ~we;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: byte enables, store replication, alignment
// checking and load lane selection with sign/zero extension.
module rv_lsu_align
  import rv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [LSU_BE_W-1:0]   be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  misaligned_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        align_err_s;

  // Request side: enables, replicated store lanes and the legality flag.
  always_comb begin
    be_o        = 4'b0000;
    wdata_o     = wdata_i;
    align_err_s = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o     = {2{wdata_i[15:0]}};
        align_err_s = addr_lo_i[0];
      end
      2'b10: begin
        be_o        = 4'b1111;
        wdata_o     = wdata_i;
        align_err_s = (addr_lo_i != 2'b00);
      end
      default: begin
        be_o        = 4'b0000;
        wdata_o     = wdata_i;
        align_err_s = 1'b0;
      end
    endcase
    misaligned_o = align_err_s | ~lsu_funct3_legal(funct3_i, we_i);
  end

  // Response side: pick the addressed lane, then extend per funct3.
  always_comb begin
    case (addr_lo_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (funct3_i)
      LSU_B:   rdata_o = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
      LSU_BU:  rdata_o = {{(DATA_WIDTH-8){1'b0}}, byte_s};
      LSU_H:   rdata_o = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
      LSU_HU:  rdata_o = {{(DATA_WIDTH-16){1'b0}}, half_s};
      LSU_W:   rdata_o = rdata_i;
      default: rdata_o = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/rv_lsu_bus_bridge.sv
// Load/store unit bridging the core's DMEM port onto a req/gnt/rvalid bus,
// stalling the core until the response has been captured.
module rv_lsu_bus_bridge
  import rv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_funct3_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_stall_o,
  output logic                  lsu_misaligned_o,
  output logic                  lsu_err_o,
  output logic                  bus_req_o,
  input  logic                  bus_gnt_i,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_we_o,
  output logic [LSU_BE_W-1:0]   bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_err_i
);

  lsu_state_e            state_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [LSU_BE_W-1:0]   be_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [DATA_WIDTH-1:0] load_ext_s;
  logic                  misaligned_s;
  logic                  start_s;

  rv_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .we_i         (lsu_we_i),
    .funct3_i     (lsu_funct3_i),
    .addr_lo_i    (lsu_addr_i[1:0]),
    .wdata_i      (lsu_wdata_i),
    .rdata_i      (bus_rdata_i),
    .be_o         (be_s),
    .wdata_o      (wdata_s),
    .misaligned_o (misaligned_s),
    .rdata_o      (load_ext_s)
  );

  assign start_s = lsu_req_i & ~misaligned_s;

  // The core holds its request stable while stalled, so the bus-side
  // attributes can be driven straight from it in every state.
  assign bus_req_o        = rst_n & start_s &
                            ((state_q == LSU_IDLE) | (state_q == LSU_WAIT_GNT));
  assign bus_addr_o       = {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign bus_we_o         = lsu_we_i;
  assign bus_be_o         = be_s;
  assign bus_wdata_o      = wdata_s;
  assign lsu_stall_o      = start_s & (state_q != LSU_DONE);
  assign lsu_misaligned_o = lsu_req_i & misaligned_s;
  assign lsu_rdata_o      = (state_q == LSU_DONE) ? rdata_q : {DATA_WIDTH{1'b0}};
  assign lsu_err_o        = (state_q == LSU_DONE) & err_q;

  // Transaction FSM plus capture of the extended load result and error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      rdata_q <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (start_s) begin
            state_q <= bus_gnt_i ? LSU_WAIT_RVALID : LSU_WAIT_GNT;
          end else begin
            state_q <= LSU_IDLE;
          end
        end
        LSU_WAIT_GNT: begin
          if (bus_gnt_i) begin
            state_q <= LSU_WAIT_RVALID;
          end else begin
            state_q <= LSU_WAIT_GNT;
          end
        end
        LSU_WAIT_RVALID: begin
          if (bus_rvalid_i) begin
            state_q <= LSU_DONE;
            err_q   <= bus_err_i;
            rdata_q <= (bus_err_i | lsu_we_i) ? {DATA_WIDTH{1'b0}} : load_ext_s;
          end else begin
            state_q <= LSU_WAIT_RVALID;
          end
        end
        LSU_DONE: begin
          state_q <= LSU_IDLE;
        end
        default: begin
          state_q <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule
